i2c_target_regs: RTL

I2C_TARGET_REGS -- requirements
Module: i2c_target_regs

---
 rtl/i2c_pkg.sv | 27 ++
 rtl/i2c_target_regs_if.sv | 30 +++
 rtl/i2c_sync_edge.sv | 22 ++
 rtl/i2c_target_regs.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/i2c_pkg.sv
// Shared types for the I2C register target.
// FSM states, ACK levels and controller command codes.
package i2c_pkg;

  typedef enum logic [3:0] {
    IDLE,
    ADDR,
    ADDR_ACK,
    WORD,
    WORD_ACK,
    WRITE,
    WRITE_ACK,
    READ,
    READ_ACK
  } i2cState_t;

  localparam logic ACK  = 1'b0;
  localparam logic NACK = 1'b1;

  typedef enum logic [1:0] {
    CMD_START,
    CMD_STOP,
    CMD_WRITE,
    CMD_READ
  } i2cCmd_t;

endpackage

// File: rtl/i2c_target_regs_if.sv
// Local-side register port of the I2C target.
// master = host logic, slave = the target block.
interface i2c_target_regs_if #(
  parameter int AW = 4
);
  logic [AW-1:0] localAddr;
  logic [7:0]    localReadData;
  logic          regWriteStrobe;
  logic [AW-1:0] regWriteAddr;
  logic [7:0]    regWriteData;
  logic          busy;

  modport master (
    output localAddr,
    input  localReadData,
    input  regWriteStrobe,
    input  regWriteAddr,
    input  regWriteData,
    input  busy
  );

  modport slave (
    input  localAddr,
    output localReadData,
    output regWriteStrobe,
    output regWriteAddr,
    output regWriteData,
    output busy
  );
endinterface

// File: rtl/i2c_sync_edge.sv
// Two-flop synchronizer with rise/fall detect.
// Flops reset to 1 so an idle bus reads high.
module i2c_sync_edge (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic q,
  output logic rise,
  output logic fall
);
  logic [2:0] sh;

  // shift the async input through sync and history flops
  always_ff @(posedge clk) begin
    if (reset) sh <= 3'b111;
    else       sh <= {sh[1:0], din};
  end

  assign q    = sh[1];
  assign rise = sh[1] & ~sh[2];
  assign fall = ~sh[1] & sh[2];
endmodule

// File: rtl/i2c_target_regs.sv
// I2C target exposing a small register file.
// Word pointer persists; writes auto-increment and wrap.
module i2c_target_regs
  import i2c_pkg::*;
#(
  parameter logic [6:0] TARGET_ADDR = 7'h50,
  parameter int         REG_COUNT   = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic i2cScl,
  inout  wire  i2cSda,
  i2c_target_regs_if.slave regIf
);
  localparam int AW = $clog2(REG_COUNT);
  localparam logic [AW-1:0] ONE = 1;

  logic sclQ, sclRise, sclFall;
  logic sdaQ, sdaRise, sdaFall;
  logic [1:0] warm;
  logic live, startEv, stopEv;
  logic [7:0] rxByte;

  i2cState_t state;
  logic [7:0] shiftReg;
  logic [7:0] txByte;
  logic [3:0] bitCnt;
  logic [AW-1:0] ptr;
  logic sdaLow, busyR, strobeR;
  logic [AW-1:0] wAddr;
  logic [7:0] wData;
  logic [7:0] regFile [REG_COUNT];

  i2c_sync_edge uScl (
    .clk(clk), .reset(reset), .din(i2cScl),
    .q(sclQ), .rise(sclRise), .fall(sclFall)
  );

  i2c_sync_edge uSda (
    .clk(clk), .reset(reset), .din(i2cSda),
    .q(sdaQ), .rise(sdaRise), .fall(sdaFall)
  );

  // mask bogus edges while synchronizers refill after reset
  assign live    = (warm == 2'd3);
  assign startEv = live & sclQ & sdaFall;
  assign stopEv  = live & sclQ & sdaRise;
  assign rxByte  = {shiftReg[6:0], sdaQ};

  // protocol FSM, pointer, register file and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      shiftReg <= '0;
      txByte   <= '0;
      bitCnt   <= '0;
      ptr      <= '0;
      sdaLow   <= 1'b0;
      busyR    <= 1'b0;
      strobeR  <= 1'b0;
      wAddr    <= '0;
      wData    <= '0;
      warm     <= '0;
      for (int i = 0; i < REG_COUNT; i++)
        regFile[i] <= '0;
    end else begin
      strobeR <= 1'b0;
      if (!live) warm <= warm + 2'd1;
      if (stopEv) begin
        state  <= IDLE;
        sdaLow <= 1'b0;
        busyR  <= 1'b0;
        bitCnt <= '0;
      end else if (startEv) begin
        state  <= ADDR;
        sdaLow <= 1'b0;
        bitCnt <= '0;
      end else begin
        unique case (state)
          IDLE: ;
          ADDR: begin
            if (sclRise && bitCnt != 4'd8) begin
              shiftReg <= rxByte;
              bitCnt   <= bitCnt + 4'd1;
            end else if (sclFall && bitCnt == 4'd8) begin
              bitCnt <= '0;
              if (shiftReg[7:1] == TARGET_ADDR) begin
                state  <= ADDR_ACK;
                sdaLow <= 1'b1;
                busyR  <= 1'b1;
              end else begin
                state <= IDLE;
                busyR <= 1'b0;
              end
            end
          end
          ADDR_ACK: begin
            if (sclFall) begin
              bitCnt <= '0;
              if (shiftReg[0]) begin
                state  <= READ;
                txByte <= regFile[ptr];
                sdaLow <= ~regFile[ptr][7];
              end else begin
                state  <= WORD;
                sdaLow <= 1'b0;
              end
            end
          end
          WORD: begin
            if (sclRise && bitCnt != 4'd8) begin
              shiftReg <= rxByte;
              bitCnt   <= bitCnt + 4'd1;
            end else if (sclFall && bitCnt == 4'd8) begin
              ptr    <= shiftReg[AW-1:0];
              sdaLow <= 1'b1;
              bitCnt <= '0;
              state  <= WORD_ACK;
            end
          end
          WORD_ACK: begin
            if (sclFall) begin
              sdaLow <= 1'b0;
              state  <= WRITE;
            end
          end
          WRITE: begin
            if (sclRise && bitCnt != 4'd8) begin
              shiftReg <= rxByte;
              bitCnt   <= bitCnt + 4'd1;
              if (bitCnt == 4'd7) begin
                regFile[ptr] <= rxByte;
                strobeR      <= 1'b1;
                wAddr        <= ptr;
                wData        <= rxByte;
                ptr          <= ptr + ONE;
              end
            end else if (sclFall && bitCnt == 4'd8) begin
              sdaLow <= 1'b1;
              bitCnt <= '0;
              state  <= WRITE_ACK;
            end
          end
          WRITE_ACK: begin
            if (sclFall) begin
              sdaLow <= 1'b0;
              state  <= WRITE;
            end
          end
          READ: begin
            if (sclRise && bitCnt != 4'd8) begin
              bitCnt <= bitCnt + 4'd1;
            end else if (sclFall) begin
              if (bitCnt == 4'd8) begin
                sdaLow <= 1'b0;
                bitCnt <= '0;
                state  <= READ_ACK;
              end else begin
                txByte <= {txByte[6:0], 1'b0};
                sdaLow <= ~txByte[6];
              end
            end
          end
          READ_ACK: begin
            if (sclRise) begin
              if (sdaQ == NACK) begin
                state <= IDLE;
                busyR <= 1'b0;
              end else begin
                ptr <= ptr + ONE;
              end
            end else if (sclFall) begin
              state  <= READ;
              bitCnt <= '0;
              txByte <= regFile[ptr];
              sdaLow <= ~regFile[ptr][7];
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign i2cSda = sdaLow ? 1'b0 : 1'bz;

  assign regIf.localReadData  = regFile[regIf.localAddr];
  assign regIf.regWriteStrobe = strobeR;
  assign regIf.regWriteAddr   = wAddr;
  assign regIf.regWriteData   = wData;
  assign regIf.busy           = busyR;
endmodule
